// File: rtl/scan_sel_pkg.sv
// Shared constants and state encoding for the scan select generator.
package scan_sel_pkg;

    localparam int unsigned SEL_W  = 3;
    localparam int unsigned NUM_CH = 2 ** SEL_W;

    localparam logic MODE_ONESHOT = 1'b0;
    localparam logic MODE_CONT    = 1'b1;

    typedef enum logic {
        ST_IDLE,
        ST_DWELL
    } state_t;

endpackage

// File: rtl/scan_next_chan.sv
// Combinational search for the next enabled channel above i_cur, wrapping modulo 2**SEL_W.
// With i_cur = 2**SEL_W-1 the result is the lowest enabled channel.
module scan_next_chan #(
    parameter int unsigned SEL_W = scan_sel_pkg::SEL_W
) (
    input  logic [2**SEL_W-1:0] i_mask,
    input  logic [SEL_W-1:0]    i_cur,
    output logic [SEL_W-1:0]    o_next,
    output logic                o_wrap
);

    localparam int unsigned CH_N = 2 ** SEL_W;

    logic             w_found;
    logic [SEL_W-1:0] w_idx;

    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        o_next  = i_cur;
        for (int unsigned k = 1; k <= CH_N; k++) begin
            w_idx = i_cur + SEL_W'(k);
            if (!w_found && i_mask[w_idx]) begin
                o_next  = w_idx;
                w_found = 1'b1;
            end
        end
        // Landing on or below the current index means the search wrapped.
        o_wrap = (o_next <= i_cur);
    end

endmodule

// File: rtl/scan_sel_gen.sv
// Sequential select generator: steps through enabled channels of a latched mask,
// holding each for a programmable dwell and waiting on downstream ready.
module scan_sel_gen #(
    parameter int unsigned SEL_W   = scan_sel_pkg::SEL_W,
    parameter int unsigned DWELL_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 mode,
    input  logic [2**SEL_W-1:0]  chan_mask,
    input  logic [DWELL_W-1:0]   dwell,
    input  logic                 sel_ready,
    output logic [SEL_W-1:0]     sel,
    output logic                 sel_valid,
    output logic                 sel_step,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    import scan_sel_pkg::*;

    localparam int unsigned CH_N = 2 ** SEL_W;

    state_t             r_state,     w_state_nxt;
    logic [SEL_W-1:0]   r_sel,       w_sel_nxt;
    logic               r_valid,     w_valid_nxt;
    logic               r_step,      w_step_nxt;
    logic               r_busy,      w_busy_nxt;
    logic               r_done,      w_done_nxt;
    logic               r_err,       w_err_nxt;
    logic [CH_N-1:0]    r_mask,      w_mask_nxt;
    logic [DWELL_W-1:0] r_dwell,     w_dwell_nxt;
    logic               r_mode,      w_mode_nxt;
    logic [DWELL_W-1:0] r_cnt,       w_cnt_nxt;

    logic [SEL_W-1:0]   w_first;
    logic               w_first_wrap;
    logic [SEL_W-1:0]   w_next;
    logic               w_next_wrap;
    logic [DWELL_W-1:0] w_dwell_eff;

    // Lowest-enabled search runs on the live mask because it is latched on the same edge.
    scan_next_chan #(.SEL_W(SEL_W)) u_first (
        .i_mask (chan_mask),
        .i_cur  (SEL_W'(CH_N - 1)),
        .o_next (w_first),
        .o_wrap (w_first_wrap)
    );

    scan_next_chan #(.SEL_W(SEL_W)) u_next (
        .i_mask (r_mask),
        .i_cur  (r_sel),
        .o_next (w_next),
        .o_wrap (w_next_wrap)
    );

    assign w_dwell_eff = (dwell == '0) ? DWELL_W'(1) : dwell;

    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_valid_nxt = r_valid;
        w_step_nxt  = 1'b0;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        w_mask_nxt  = r_mask;
        w_dwell_nxt = r_dwell;
        w_mode_nxt  = r_mode;
        w_cnt_nxt   = r_cnt;

        unique case (r_state)
            ST_IDLE: begin
                if (start && !stop) begin
                    if (chan_mask != '0) begin
                        w_mask_nxt  = chan_mask;
                        w_dwell_nxt = w_dwell_eff;
                        w_mode_nxt  = mode;
                        w_state_nxt = ST_DWELL;
                        w_sel_nxt   = w_first;
                        w_valid_nxt = 1'b1;
                        w_step_nxt  = 1'b1;
                        w_busy_nxt  = 1'b1;
                        w_cnt_nxt   = w_dwell_eff;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            ST_DWELL: begin
                if (stop) begin
                    w_state_nxt = ST_IDLE;
                    w_valid_nxt = 1'b0;
                    w_busy_nxt  = 1'b0;
                end else if (r_cnt == DWELL_W'(1)) begin
                    if (sel_ready) begin
                        if (w_next_wrap && (r_mode == MODE_ONESHOT)) begin
                            w_state_nxt = ST_IDLE;
                            w_valid_nxt = 1'b0;
                            w_busy_nxt  = 1'b0;
                            w_done_nxt  = 1'b1;
                        end else begin
                            w_sel_nxt  = w_next;
                            w_step_nxt = 1'b1;
                            w_cnt_nxt  = r_dwell;
                        end
                    end
                end else begin
                    w_cnt_nxt = r_cnt - DWELL_W'(1);
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_sel   <= '0;
            r_valid <= 1'b0;
            r_step  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_mask  <= '0;
            r_dwell <= '0;
            r_mode  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            r_valid <= w_valid_nxt;
            r_step  <= w_step_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
            r_mask  <= w_mask_nxt;
            r_dwell <= w_dwell_nxt;
            r_mode  <= w_mode_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign sel       = r_sel;
    assign sel_valid = r_valid;
    assign sel_step  = r_step;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;

endmodule

// File: tb/tb_scan_sel_gen.sv
// Directed-vector bench for scan_sel_gen; inputs change and outputs are sampled on the falling edge.
module tb_scan_sel_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, stop, mode, sel_ready;
    logic [7:0]  chan_mask;
    logic [15:0] dwell;
    logic [2:0]  sel;
    logic        sel_valid, sel_step, busy, done, err;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    scan_sel_gen #(.SEL_W(3), .DWELL_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stop      (stop),
        .mode      (mode),
        .chan_mask (chan_mask),
        .dwell     (dwell),
        .sel_ready (sel_ready),
        .sel       (sel),
        .sel_valid (sel_valid),
        .sel_step  (sel_step),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic begin_scan(input logic [7:0] m, input logic [15:0] d, input logic md);
        chan_mask = m;
        dwell     = d;
        mode      = md;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    int unsigned exp_sel1 [12] = '{0, 0, 0, 2, 2, 2, 5, 5, 5, 7, 7, 7};

    initial begin
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; mode = 1'b0;
        sel_ready = 1'b1; chan_mask = '0; dwell = '0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        check("rst_sel",   sel,       0);
        check("rst_valid", sel_valid, 0);
        check("rst_step",  sel_step,  0);
        check("rst_busy",  busy,      0);
        check("rst_done",  done,      0);
        check("rst_err",   err,       0);

        // One-shot pass over channels 0,2,5,7 with dwell 3.
        begin_scan(8'b1010_0101, 16'd3, 1'b0);
        for (int i = 0; i < 12; i++) begin
            check("t1_sel",   sel,       exp_sel1[i]);
            check("t1_step",  sel_step,  (i % 3) == 0);
            check("t1_valid", sel_valid, 1);
            check("t1_done",  done,      0);
            tick();
        end
        check("t1_done_pulse", done,      1);
        check("t1_valid_off",  sel_valid, 0);
        check("t1_busy_off",   busy,      0);
        check("t1_sel_keep",   sel,       7);
        tick();
        check("t1_done_1cyc",  done,      0);

        // Continuous, all channels, dwell 0 behaves as 1.
        begin_scan(8'hFF, 16'd0, 1'b1);
        for (int i = 0; i < 12; i++) begin
            check("t2_sel",  sel,      i % 8);
            check("t2_step", sel_step, 1);
            check("t2_done", done,     0);
            if (i == 11) break;
            tick();
        end
        tick();
        check("t2_sel4", sel, 4);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("t2_stop_valid", sel_valid, 0);
        check("t2_stop_busy",  busy,      0);
        check("t2_stop_done",  done,      0);
        tick();
        check("t2_stop_done2", done,      0);

        // Single channel continuous; a mid-scan start with a new mask is ignored.
        begin_scan(8'b0001_0000, 16'd2, 1'b1);
        for (int i = 0; i < 8; i++) begin
            check("t3_sel",   sel,       4);
            check("t3_step",  sel_step,  (i % 2) == 0);
            check("t3_valid", sel_valid, 1);
            if (i == 3) begin
                chan_mask = 8'h01;
                start     = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("t3_stop_valid", sel_valid, 0);

        // Ready held low for 5 cycles at the first expiry.
        begin_scan(8'b0000_0011, 16'd2, 1'b0);
        for (int i = 0; i < 7; i++) begin
            check("t4_hold_sel", sel,      0);
            check("t4_hold_step", sel_step, i == 0);
            sel_ready = (i >= 1 && i <= 5) ? 1'b0 : 1'b1;
            tick();
        end
        check("t4_adv_sel",  sel,      1);
        check("t4_adv_step", sel_step, 1);
        tick();
        check("t4_sel1_hold", sel,  1);
        check("t4_no_done",   done, 0);
        tick();
        check("t4_done",      done,      1);
        check("t4_valid_off", sel_valid, 0);

        // Empty mask raises err; start with stop does nothing.
        begin_scan(8'h00, 16'd4, 1'b0);
        check("t5_err",       err,       1);
        check("t5_err_valid", sel_valid, 0);
        tick();
        check("t5_err_1cyc",  err,       0);
        stop = 1'b1;
        begin_scan(8'hFF, 16'd4, 1'b1);
        stop = 1'b0;
        check("t5_ss_valid", sel_valid, 0);
        check("t5_ss_err",   err,       0);
        check("t5_ss_busy",  busy,      0);
        stop = 1'b1;
        begin_scan(8'h00, 16'd4, 1'b1);
        stop = 1'b0;
        check("t5_ss0_err",  err,       0);

        // Asynchronous reset mid-dwell.
        begin_scan(8'b0010_0000, 16'd100, 1'b1);
        tick();
        check("t6_sel5",  sel,       5);
        check("t6_busy",  busy,      1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_async_sel",   sel,       0);
        check("t6_async_valid", sel_valid, 0);
        check("t6_async_busy",  busy,      0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t6_idle_valid", sel_valid, 0);
            check("t6_idle_step",  sel_step,  0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/scan_sel_gen.md
Name: scan_sel_gen

Overview:
Sequential select generator that drives the 3-bit select input of the 3-to-8 decoder stage. It steps through the enabled channels of an 8-channel mask. Each selection is held for a programmable dwell time, and the next step waits for a downstream ready. It supports one-shot and continuous scanning, with start/stop control and completion/error pulses.

Parameters:
SEL_W, 3, select width; NUM_CH = 2**SEL_W channels
DWELL_W, 16, width of dwell count

Ports:
clk  in  1  single system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  1-cycle request to begin a scan; sampled in IDLE only
stop  in  1  synchronous abort; valid in any state
mode  in  1  0 = one-shot pass, 1 = continuous; latched at start
chan_mask  in  NUM_CH  bit i = 1 enables channel i; latched at start
dwell  in  DWELL_W  cycles each selection is held; 0 is treated as 1; latched at start
sel_ready  in  1  downstream permits advance
sel  out  SEL_W  current channel index, feeds decoder select
sel_valid  out  1  sel is meaningful
sel_step  out  1  1-cycle pulse on the first cycle of every new selection, including a repeat of the same channel
busy  out  1  high in DWELL
done  out  1  1-cycle pulse at end of a one-shot pass
err  out  1  1-cycle pulse when start arrives with an all-zero mask

Behaviour:
- Reset (async assert, sync deassert by clk): state = IDLE; sel = 0; sel_valid, sel_step, busy, done, err = 0; latched mask/dwell/mode = 0.
- States: IDLE, DWELL. done and err are registered pulses, not separate states.
- IDLE:
  - start = 1, stop = 0, chan_mask != 0 at edge N: latch mask, mode, and max(dwell,1). At N+1: state = DWELL, sel = lowest enabled index, sel_valid = 1, sel_step = 1, busy = 1, dwell counter = latched dwell.
  - start = 1 with mask == 0: err = 1 at N+1; stay IDLE.
  - start and stop in the same cycle: stop wins; no err, no scan.
- DWELL:
  - Counter decrements each cycle, saturating at 1. A selection is held for at least the latched dwell cycles, counting its sel_step cycle.
  - Advance occurs when counter == 1 and sel_ready == 1. If sel_ready is low at expiry, sel holds indefinitely until ready.
  - Next channel is the next higher enabled index, wrapping modulo NUM_CH.
  - If the search wraps (next index <= current index) and mode = 0: next cycle state = IDLE, sel_valid = 0, busy = 0, done = 1; sel keeps its last value.
  - Otherwise: sel = next index, sel_step = 1, counter reloaded.
  - Single enabled channel in continuous mode: the same index is re-presented with a new sel_step every dwell period.
- stop in DWELL: next cycle state = IDLE, sel_valid = 0, busy = 0, no done; an advance in the same cycle is discarded.
- start in DWELL is ignored. Changes to chan_mask, dwell, or mode during a scan have no effect until the next start.
- Arithmetic: the counter is unsigned DWELL_W bits. The index search is purely combinational over the latched mask, and the result is registered.
- Reset asserted mid-scan: all outputs return to reset values immediately (async).

Decomposition:
- Package scan_sel_pkg: SEL_W, NUM_CH, state enum (ST_IDLE, ST_DWELL), MODE_ONESHOT / MODE_CONT constants.
- Sub-module scan_next_chan: combinational. Inputs are mask and current index. Outputs are next enabled index (with wrap) and a wrapped flag. It also serves the lowest-enabled search, using current = NUM_CH-1 with the wrapped flag ignored.

Test Plan:
1. Reset, then mask = 8'b1010_0101, dwell = 3, mode = 0, sel_ready = 1, start at cycle 5 -> sel = 0,2,5,7, each held 3 cycles starting cycle 6. sel_step pulses at 6,9,12,15; done at 18; sel_valid low from 18.
2. mask = 8'hFF, dwell = 0, mode = 1 -> sel advances every cycle 0..7, wraps to 0, no done. stop on the cycle sel = 4 -> sel_valid = 0 next cycle, no done pulse.
3. mask = 8'b0001_0000, dwell = 2, mode = 1 -> sel stays 4, sel_step pulses every 2 cycles. start re-asserted mid-scan is ignored.
4. mask = 8'b0000_0011, dwell = 2, sel_ready held low 5 cycles at first expiry -> sel = 0 holds 2+5 cycles, then sel = 1 one cycle after sel_ready rises.
5. start with mask = 0 -> err pulse 1 cycle later, sel_valid stays 0. start with stop in the same cycle -> no activity.
6. Assert rst_n low mid-dwell with sel = 5 -> sel = 0 and sel_valid = 0 immediately, without waiting for a clk edge; after release, idle until the next start.
